mlp_load_sequencer: RTL and testbench
=====================================

# mlp_load_sequencer

Parametrised load/sequencing front end for the MLP accelerator. It accepts a packed valid/ready payload stream of input-matrix rows and per-layer weight rows, checks beat-level protocol, and writes each beat to the buffer write port. It tracks row completion per matrix and issues per-layer `start_o` pulses to the compute engine in layer order 0..LAYERS-1. It generalises the fixed 16x16x16-bit / 8-layer / 32-bit-bus load path to arbitrary element width, bus width, dimension and layer count.

## Interface
- DATA_W, 16, element width in bits
- BUS_W, 32, payload width; ELEMS = BUS_W/DATA_W elements per beat; must divide DIM
- DIM, 16, matrix dimension (rows = cols = DIM)
- LAYERS, 8, number of layers (power of two ≥ 2)
- BPR (derived) = DIM/ELEMS beats per row; RW = clog2(DIM), LW = clog2(LAYERS), CW = clog2(BPR)

- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- load_valid_i  in  1  payload beat valid
- load_ready_o  out  1  beat accepted when valid & ready
- load_payload_i  in  BUS_W  element (beat*ELEMS + k) in bits [k*DATA_W +: DATA_W]
- load_type_i  in  1  1 = input matrix, 0 = weight
- load_row_i  in  RW  row index
- load_layer_i  in  LW  layer of a weight row; ignored for inputs
- buf_we_o  out  1  buffer write strobe
- buf_sel_o  out  1  1 = input buffer, 0 = weight buffer
- buf_layer_o  out  LW  weight layer
- buf_row_o  out  RW  row
- buf_col_o  out  CW  beat (word) index in row
- buf_data_o  out  BUS_W  payload
- start_o  out  1  one-cycle start pulse for the compute engine
- start_layer_o  out  LW  layer being started; held valid through RUN
- compute_done_i  in  1  one-cycle pulse from the engine, layer finished
- all_done_o  out  1  one-cycle pulse after the last layer completes
- err_o  out  1  sticky protocol error

## Operation
- FSM states: LOAD, START, RUN, FIN.
- LOAD: `load_ready_o` = 1. Every accepted beat is written; `beat_cnt` increments and wraps at BPR.
  - Beat 0 latches type/row/layer.
  - Beats 1..BPR-1 must match the latched type/row/layer (layer compared for weights only).
  - On a mismatch: set `err_o`, drop the partial row (no completion bit), and treat the beat as beat 0 of the new row. The beat is still written.
- Last beat (beat BPR-1) sets a completion bit: `in_done[row]`, or `wt_done[layer][row]`.
- Reloading a completed row overwrites the data, leaves the bit set, and is not an error.
- `cur_layer` starts at 0. Leave LOAD for START when `in_done` is all ones and `wt_done[cur_layer]` is all ones.
- START: `start_o` = 1 and `start_layer_o` = `cur_layer`; go to RUN next cycle.
- RUN: `load_ready_o` = 0. On `compute_done_i`:
  - clear `wt_done[cur_layer]`;
  - if `cur_layer` == LAYERS-1, go to FIN;
  - else increment `cur_layer` and return to LOAD. Later-layer weights may already be complete, in which case START follows immediately.
- FIN: `all_done_o` = 1 for one cycle; clear `in_done`, reset `cur_layer` to 0, and go to LOAD.
- `compute_done_i` outside RUN is ignored. `err_o` clears only on reset.
- A partial row in progress across a START is kept; loading resumes at the same beat on return to LOAD.

## Timing
- Reset (synchronous) sets:
  - state LOAD, `load_ready_o` = 1;
  - `buf_we_o` = 0; `buf_sel_o`, `buf_layer_o`, `buf_row_o`, `buf_col_o`, `buf_data_o` = 0;
  - `start_o` = 0, `start_layer_o` = 0, `all_done_o` = 0, `err_o` = 0;
  - all completion bits, `beat_cnt` and `cur_layer` = 0.
- A reset mid-load or mid-RUN discards everything.
- Buffer write port is registered: a beat accepted at edge N gives `buf_we_o` = 1 with its fields during cycle N+1.
- A completion bit set at edge N makes the LOAD→START decision at edge N+1, so `start_o` is high in cycle N+2. The final buffer write (cycle N+1) always precedes `start_o`.
- `load_ready_o` is a registered function of state: low from the START cycle through RUN, high again the cycle after the LOAD transition.
- `compute_done_i` sampled at edge M gives LOAD at M+1, and `start_o` at M+2 at the earliest.
- `err_o` rises in the cycle after the offending beat is accepted.

## Test plan
- Defaults, all-ones data: load 16 input rows (8 beats each), then 16 weight rows for layer 0 → 256 writes with correct row/col/sel; `start_o` pulses once with layer 0, exactly 2 cycles after the last beat; `load_ready_o` = 0 in RUN.
- Load all 8 layers' weights before the first done; pulse `compute_done_i` 8 times → `start_layer_o` = 0..7, each start 2 cycles after its done; `all_done_o` after the 8th done; `in_done` is cleared (a new start needs a fresh input load).
- Change `load_row_i` 3→4 at beat 5 → `err_o` = 1; row 3 is incomplete; the beat is written as row 4 col 0; no start until row 3 is reloaded fully.
- Omit weight row 15 of layer 0 → no `start_o`. Reload input row 2 twice → no error; start fires after row 15 is loaded.
- Assert rst_n = 0 for one cycle mid-RUN → all outputs at reset values; a subsequent done pulse is ignored; a full reload restarts at layer 0.
- Parameters DATA_W = 8, BUS_W = 64, DIM = 32, LAYERS = 4 → BPR = 4, `buf_col_o` wraps 0..3; 4 layers sequenced; all_done after the 4th done.

Source files
------------

// File: rtl/mlp_load_sequencer.sv
// Load front end for the MLP accelerator: writes row beats into the input/weight buffers
// and sequences one start pulse per layer once inputs and that layer's weights are present.
//   state   | meaning
//   S_LOAD  | accepting beats; waiting for all input rows and all current-layer weight rows
//   S_START | one-cycle start pulse to the compute engine
//   S_RUN   | engine busy, loading stalled, waiting for compute_done_i
//   S_FIN   | last layer finished: all_done pulse, input matrix invalidated
module mlp_load_sequencer #(
  parameter  int DATA_W = 16,
  parameter  int BUS_W  = 32,
  parameter  int DIM    = 16,
  parameter  int LAYERS = 8,
  localparam int ELEMS  = BUS_W / DATA_W,
  localparam int BPR    = DIM / ELEMS,
  localparam int RW     = $clog2(DIM),
  localparam int LW     = $clog2(LAYERS),
  localparam int CW     = (BPR > 1) ? $clog2(BPR) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid_i,
  output logic             load_ready_o,
  input  logic [BUS_W-1:0] load_payload_i,
  input  logic             load_type_i,
  input  logic [RW-1:0]    load_row_i,
  input  logic [LW-1:0]    load_layer_i,
  output logic             buf_we_o,
  output logic             buf_sel_o,
  output logic [LW-1:0]    buf_layer_o,
  output logic [RW-1:0]    buf_row_o,
  output logic [CW-1:0]    buf_col_o,
  output logic [BUS_W-1:0] buf_data_o,
  output logic             start_o,
  output logic [LW-1:0]    start_layer_o,
  input  logic             compute_done_i,
  output logic             all_done_o,
  output logic             err_o
);

  typedef enum logic [1:0] {S_LOAD, S_START, S_RUN, S_FIN} state_t;

  localparam logic [CW-1:0] LAST_BEAT  = CW'(BPR - 1);
  localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ready;
  logic [CW-1:0]    r_beat_cnt;
  logic             r_lat_type;
  logic [RW-1:0]    r_lat_row;
  logic [LW-1:0]    r_lat_layer;
  logic [DIM-1:0]   r_in_done;
  logic [DIM-1:0]   r_wt_done [LAYERS];
  logic [LW-1:0]    r_cur_layer;
  logic             r_err;
  logic             r_buf_we;
  logic             r_buf_sel;
  logic [LW-1:0]    r_buf_layer;
  logic [RW-1:0]    r_buf_row;
  logic [CW-1:0]    r_buf_col;
  logic [BUS_W-1:0] r_buf_data;

  logic             w_accept;
  logic             w_mismatch;
  logic [CW-1:0]    w_beat;
  logic             w_last;
  logic             w_in_full;
  logic             w_wt_full;
  logic             w_start;
  logic             w_all_done;

  assign w_accept   = load_valid_i & r_ready;
  // A beat that disagrees with the row in progress abandons it and opens a new row.
  assign w_mismatch = (r_beat_cnt != '0) &&
                      ((load_type_i != r_lat_type) || (load_row_i != r_lat_row) ||
                       (!load_type_i && (load_layer_i != r_lat_layer)));
  assign w_beat     = w_mismatch ? '0 : r_beat_cnt;
  assign w_last     = (w_beat == LAST_BEAT);
  assign w_in_full  = &r_in_done;
  assign w_wt_full  = &r_wt_done[r_cur_layer];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == S_LOAD);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_all_done  = 1'b0;
    case (r_state)
      S_LOAD: begin
        if (w_in_full && w_wt_full) w_state_nxt = S_START;
      end
      S_START: begin
        w_start     = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (compute_done_i) w_state_nxt = (r_cur_layer == LAST_LAYER) ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        w_all_done  = 1'b1;
        w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat_cnt  <= '0;
      r_lat_type  <= 1'b0;
      r_lat_row   <= '0;
      r_lat_layer <= '0;
    end else if (w_accept) begin
      r_beat_cnt <= w_last ? '0 : w_beat + CW'(1);
      if (w_beat == '0) begin
        r_lat_type  <= load_type_i;
        r_lat_row   <= load_row_i;
        r_lat_layer <= load_layer_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_accept && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_we    <= 1'b0;
      r_buf_sel   <= 1'b0;
      r_buf_layer <= '0;
      r_buf_row   <= '0;
      r_buf_col   <= '0;
      r_buf_data  <= '0;
    end else begin
      r_buf_we <= w_accept;
      if (w_accept) begin
        r_buf_sel   <= load_type_i;
        r_buf_layer <= load_type_i ? '0 : load_layer_i;
        r_buf_row   <= load_row_i;
        r_buf_col   <= w_beat;
        r_buf_data  <= load_payload_i;
      end
    end
  end

  // Completion bits: set on a row's last beat, cleared per layer on done and for inputs on finish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_done <= '0;
      for (int l = 0; l < LAYERS; l++) r_wt_done[l] <= '0;
    end else begin
      if (w_accept && w_last) begin
        if (load_type_i) r_in_done[load_row_i] <= 1'b1;
        else             r_wt_done[load_layer_i][load_row_i] <= 1'b1;
      end
      if ((r_state == S_RUN) && compute_done_i) r_wt_done[r_cur_layer] <= '0;
      if (r_state == S_FIN) r_in_done <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cur_layer <= '0;
    end else if ((r_state == S_RUN) && compute_done_i && (r_cur_layer != LAST_LAYER)) begin
      r_cur_layer <= r_cur_layer + LW'(1);
    end else if (r_state == S_FIN) begin
      r_cur_layer <= '0;
    end
  end

  assign load_ready_o  = r_ready;
  assign buf_we_o      = r_buf_we;
  assign buf_sel_o     = r_buf_sel;
  assign buf_layer_o   = r_buf_layer;
  assign buf_row_o     = r_buf_row;
  assign buf_col_o     = r_buf_col;
  assign buf_data_o    = r_buf_data;
  assign start_o       = w_start;
  assign start_layer_o = r_cur_layer;
  assign all_done_o    = w_all_done;
  assign err_o         = r_err;

endmodule

// File: tb/tb_mlp_load_sequencer.sv
// Bench for mlp_load_sequencer: random row data/order against a row-set/layer-pointer model,
// plus a small-parameter instance (8b elements, 64b bus, 32x32, 4 layers).
module tb_mlp_load_sequencer;

  localparam int DIM = 16;
  localparam int L   = 8;
  localparam int BPR = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        lv = 1'b0, lt = 1'b0, done = 1'b0;
  logic [3:0]  lr = '0;
  logic [2:0]  ll = '0;
  logic [31:0] lp = '0;
  logic        load_ready, buf_we, buf_sel, start, all_done, err;
  logic [2:0]  buf_layer, buf_col, start_layer;
  logic [3:0]  buf_row;
  logic [31:0] buf_data;

  mlp_load_sequencer u_dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(lv), .load_ready_o(load_ready), .load_payload_i(lp),
    .load_type_i(lt), .load_row_i(lr), .load_layer_i(ll),
    .buf_we_o(buf_we), .buf_sel_o(buf_sel), .buf_layer_o(buf_layer),
    .buf_row_o(buf_row), .buf_col_o(buf_col), .buf_data_o(buf_data),
    .start_o(start), .start_layer_o(start_layer), .compute_done_i(done),
    .all_done_o(all_done), .err_o(err)
  );

  logic        lv2 = 1'b0, lt2 = 1'b0, done2 = 1'b0;
  logic [4:0]  lr2 = '0;
  logic [1:0]  ll2 = '0;
  logic [63:0] lp2 = '0;
  logic        rdy2, we2, sel2, start2, all2, err2;
  logic [1:0]  layer2, col2, sl2;
  logic [4:0]  row2;
  logic [63:0] data2;

  mlp_load_sequencer #(.DATA_W(8), .BUS_W(64), .DIM(32), .LAYERS(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .load_valid_i(lv2), .load_ready_o(rdy2), .load_payload_i(lp2),
    .load_type_i(lt2), .load_row_i(lr2), .load_layer_i(ll2),
    .buf_we_o(we2), .buf_sel_o(sel2), .buf_layer_o(layer2),
    .buf_row_o(row2), .buf_col_o(col2), .buf_data_o(data2),
    .start_o(start2), .start_layer_o(sl2), .compute_done_i(done2),
    .all_done_o(all2), .err_o(err2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: sets of completed rows, current layer, and whether a layer is running.
  typedef struct {bit sel; int layer; int row; int col; logic [31:0] data;} wr_t;
  wr_t exp_wr[$];
  int  exp_start_c[$], exp_start_l[$], obs_start_c[$], obs_start_l[$];
  int  exp_all[$], obs_all[$];
  bit  m_in [DIM];
  bit  m_wt [L][DIM];
  int  m_cur = 0;
  bit  m_run = 0;
  int  m_start_cyc = 0;
  int  m_err_cyc = -1;
  int  n_wr = 0;
  bit  mon_en = 0;

  always @(negedge clk) begin : mon
    wr_t w;
    if (mon_en) begin
      check_val("buf_we", buf_we, exp_wr.size() != 0);
      if (buf_we && exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        n_wr++;
        check_val("buf_sel", buf_sel, w.sel);
        check_val("buf_row", buf_row, w.row);
        check_val("buf_col", buf_col, w.col);
        check_val("buf_data", buf_data, w.data);
        if (!w.sel) check_val("buf_layer", buf_layer, w.layer);
      end
      if (start) begin
        obs_start_c.push_back(cyc);
        obs_start_l.push_back(int'(start_layer));
      end
      if (all_done) obs_all.push_back(cyc);
      check_val("err_o", err, (m_err_cyc >= 0) && (cyc >= m_err_cyc));
    end
  end

  function automatic void model_reset();
    for (int r = 0; r < DIM; r++) begin
      m_in[r] = 0;
      for (int l = 0; l < L; l++) m_wt[l][r] = 0;
    end
    m_cur = 0; m_run = 0; m_err_cyc = -1;
  endfunction

  // k = cycle in which the deciding event was presented; start follows two cycles later
  function automatic void eval_start(input int k);
    bit full = 1;
    for (int r = 0; r < DIM; r++) if (!m_in[r] || !m_wt[m_cur][r]) full = 0;
    if (!m_run && full) begin
      exp_start_c.push_back(k + 2);
      exp_start_l.push_back(m_cur);
      m_run = 1;
      m_start_cyc = k + 2;
    end
  endfunction

  task automatic send_beat(input bit t, input int r, input int l, input int col, input bit e,
                           output int k);
    wr_t w;
    int  waits = 0;
    k = 0;
    @(negedge clk);
    lv = 1'b1; lt = t; lr = 4'(r); lp = $urandom;
    ll = t ? 3'($urandom) : 3'(l);
    while (!load_ready && waits < 100) begin @(negedge clk); waits++; end
    if (!load_ready) begin
      check_val("ready_wait", load_ready, 1);
      lv = 1'b0;
      return;
    end
    k = cyc;
    w.sel = t; w.layer = l; w.row = r; w.col = col; w.data = lp;
    @(posedge clk);
    #1;
    lv = 1'b0;
    exp_wr.push_back(w);
    if (e && m_err_cyc < 0) m_err_cyc = k + 1;
  endtask

  task automatic send_row(input bit t, input int r, input int l, input bit e);
    int k;
    for (int b = 0; b < BPR; b++) begin
      send_beat(t, r, l, b, (b == 0) && e, k);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    if (t) m_in[r] = 1;
    else   m_wt[l][r] = 1;
    eval_start(k);
  endtask

  task automatic load_rows(input bit t, input int l);
    int ord[DIM];
    for (int i = 0; i < DIM; i++) ord[i] = i;
    for (int i = DIM - 1; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int s = ord[i];
      ord[i] = ord[j];
      ord[j] = s;
    end
    for (int i = 0; i < DIM; i++) send_row(t, ord[i], l, 0);
  endtask

  task automatic pulse_done();
    int k;
    @(negedge clk);
    done = 1'b1;
    k = cyc;
    @(posedge clk);
    #1;
    done = 1'b0;
    if (m_run && k > m_start_cyc) begin
      for (int r = 0; r < DIM; r++) m_wt[m_cur][r] = 0;
      m_run = 0;
      if (m_cur == L - 1) begin
        exp_all.push_back(k + 1);
        for (int r = 0; r < DIM; r++) m_in[r] = 0;
        m_cur = 0;
      end else begin
        m_cur++;
        eval_start(k);
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    int g = 0;
    while (cyc < target && g < 1000) begin @(negedge clk); g++; end
  endtask

  task automatic compare_events();
    repeat (4) @(negedge clk);
    check_val("start_count", obs_start_c.size(), exp_start_c.size());
    for (int i = 0; i < exp_start_c.size() && i < obs_start_c.size(); i++) begin
      check_val("start_cycle", obs_start_c[i], exp_start_c[i]);
      check_val("start_layer", obs_start_l[i], exp_start_l[i]);
    end
    check_val("all_done_count", obs_all.size(), exp_all.size());
    for (int i = 0; i < exp_all.size() && i < obs_all.size(); i++)
      check_val("all_done_cycle", obs_all[i], exp_all[i]);
    exp_start_c.delete(); exp_start_l.delete(); obs_start_c.delete(); obs_start_l.delete();
    exp_all.delete(); obs_all.delete();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_ready", load_ready, 1);
    check_val("rst_we", buf_we, 0);
    check_val("rst_sel", buf_sel, 0);
    check_val("rst_layer", buf_layer, 0);
    check_val("rst_row", buf_row, 0);
    check_val("rst_col", buf_col, 0);
    check_val("rst_data", buf_data, 0);
    check_val("rst_start", start, 0);
    check_val("rst_start_layer", start_layer, 0);
    check_val("rst_all_done", all_done, 0);
    check_val("rst_err", err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
  endtask

  task automatic send2(input bit t, input int r, input int l);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check_val("d2_ready", rdy2, 1);
      lv2 = 1'b1; lt2 = t; lr2 = 5'(r); ll2 = 2'(l); lp2 = {$urandom, $urandom};
      @(posedge clk);
      #1;
      lv2 = 1'b0;
      @(negedge clk);
      check_val("d2_we", we2, 1);
      check_val("d2_col", col2, b);
      check_val("d2_row", row2, r);
      check_val("d2_sel", sel2, t);
      check_val("d2_data", data2, lp2);
      if (!t) check_val("d2_layer", layer2, l);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    mon_en = 1;
    check_reset_outputs();
    rst_n = 1'b1;

    // inputs then layer 0 weights: 256 writes, single start for layer 0, ready low in RUN
    n_wr = 0;
    load_rows(1, 0);
    load_rows(0, 0);
    wait_cyc(m_start_cyc);
    for (int i = 0; i < 4; i++) begin
      check_val("ready_in_run", load_ready, 0);
      @(negedge clk);
    end
    check_val("n_writes", n_wr, 2 * DIM * BPR);
    compare_events();
    pulse_done();
    @(negedge clk);
    check_val("ready_after_done", load_ready, 1);
    compare_events();

    // all layers preloaded, then eight done pulses
    do_reset();
    begin
      int lo[L];
      for (int i = 0; i < L; i++) lo[i] = i;
      for (int i = L - 1; i > 0; i--) begin
        int j = $urandom_range(0, i);
        int s = lo[i];
        lo[i] = lo[j];
        lo[j] = s;
      end
      for (int i = 0; i < L; i++) load_rows(0, lo[i]);
    end
    load_rows(1, 0);
    for (int i = 0; i < L; i++) begin
      wait_cyc(m_start_cyc + 1 + $urandom_range(0, 3));
      pulse_done();
    end
    compare_events();
    load_rows(0, 0);
    pulse_done();
    compare_events();

    // row change mid-row: error, partial row dropped until reloaded
    do_reset();
    load_rows(0, 0);
    for (int r = 0; r < 3; r++) send_row(1, r, 0, 0);
    for (int b = 0; b < 5; b++) begin
      int k;
      send_beat(1, 3, 0, b, 0, k);
    end
    send_row(1, 4, 0, 1);
    for (int r = 5; r < DIM; r++) send_row(1, r, 0, 0);
    compare_events();
    check_val("err_sticky", err, 1);
    send_row(1, 3, 0, 0);
    compare_events();

    // missing weight row blocks start; input reloads are harmless; stray done ignored
    do_reset();
    for (int r = 0; r < DIM; r++) begin
      send_row(1, r, 0, 0);
      if (r == 7) begin
        send_row(1, 2, 0, 0);
        send_row(1, 2, 0, 0);
      end
    end
    for (int r = 0; r < DIM - 1; r++) send_row(0, r, 0, 0);
    pulse_done();
    compare_events();
    send_row(0, DIM - 1, 0, 0);
    compare_events();

    // reset in RUN, then ignored done, full reload restarts at layer 0
    do_reset();
    pulse_done();
    compare_events();
    load_rows(0, 0);
    load_rows(1, 0);
    compare_events();

    // small-parameter instance: 4 beats per row, 4 layers
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 32; r++) send2(0, r, l);
    for (int r = 0; r < 32; r++) send2(1, r, 0);
    check_val("d2_no_early_start", start2, 0);
    @(negedge clk);
    check_val("d2_start", start2, 1);
    check_val("d2_start_layer", sl2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      done2 = 1'b1;
      check_val("d2_ready_run", rdy2, 0);
      @(negedge clk);
      done2 = 1'b0;
      check_val("d2_all_done", all2, i == 3);
      check_val("d2_start_gap", start2, 0);
      @(negedge clk);
      if (i < 3) begin
        check_val("d2_start", start2, 1);
        check_val("d2_start_layer", sl2, i + 1);
      end else begin
        check_val("d2_all_done_once", all2, 0);
        check_val("d2_ready_after", rdy2, 1);
      end
    end
    check_val("d2_err", err2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
